// File: rtl/bin_to_temporal_enc.sv
// Binary-to-temporal encoder: each channel value becomes a pulse whose rising edge
// sits at that phase of a free-running gamma cycle, one frame per gamma cycle.
module bin_to_temporal_enc #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_CHANNELS      = 4,
    localparam int W                = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                      aclk,
    input  logic                      grst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CHANNELS*W-1:0] in_values,
    input  logic [NUM_CHANNELS-1:0]   in_null,
    output logic [W-1:0]              gamma_phase,
    output logic                      gamma_start,
    output logic [NUM_CHANNELS-1:0]   pulses,
    output logic                      busy
);

    localparam logic [W-1:0] LAST_PHASE = W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [W:0]   PW_M1      = (W+1)'(PULSE_WIDTH - 1);

    logic [W-1:0]              phase_next;
    logic                      wrap;
    logic                      handshake;

    logic                      pending_valid, pending_valid_next;
    logic [NUM_CHANNELS*W-1:0] pending_values, pending_values_next;
    logic [NUM_CHANNELS-1:0]   pending_null, pending_null_next;

    logic                      active_valid, active_valid_next;
    logic [NUM_CHANNELS*W-1:0] active_values, active_values_next;
    logic [NUM_CHANNELS-1:0]   active_null, active_null_next;

    logic [NUM_CHANNELS-1:0]   pulses_next;

    assign in_ready    = ~pending_valid;
    assign handshake   = in_valid & ~pending_valid;
    assign wrap        = (gamma_phase == LAST_PHASE);
    assign phase_next  = gamma_phase + W'(1);
    assign gamma_start = (gamma_phase == '0);
    assign busy        = active_valid;

    // At the wrap edge the pending frame is promoted; an empty pending slot lets a
    // frame arriving on that same edge go straight into active.
    always_comb begin
        pending_valid_next  = pending_valid;
        pending_values_next = pending_values;
        pending_null_next   = pending_null;
        active_valid_next   = active_valid;
        active_values_next  = active_values;
        active_null_next    = active_null;

        if (wrap) begin
            if (pending_valid) begin
                active_valid_next  = 1'b1;
                active_values_next = pending_values;
                active_null_next   = pending_null;
                pending_valid_next = 1'b0;
            end else if (handshake) begin
                active_valid_next  = 1'b1;
                active_values_next = in_values;
                active_null_next   = in_null;
            end else begin
                active_valid_next  = 1'b0;
            end
        end else if (handshake) begin
            pending_valid_next  = 1'b1;
            pending_values_next = in_values;
            pending_null_next   = in_null;
        end
    end

    // Windows are evaluated one bit wider so v + PULSE_WIDTH - 1 cannot wrap;
    // since the phase never exceeds the last phase, windows truncate naturally.
    always_comb begin
        pulses_next = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            pulses_next[i] = active_valid_next && !active_null_next[i] &&
                ({1'b0, phase_next} >= {1'b0, active_values_next[i*W +: W]}) &&
                ({1'b0, phase_next} <= ({1'b0, active_values_next[i*W +: W]} + PW_M1));
        end
    end

    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            gamma_phase    <= '0;
            pending_valid  <= 1'b0;
            pending_values <= '0;
            pending_null   <= '0;
            active_valid   <= 1'b0;
            active_values  <= '0;
            active_null    <= '0;
            pulses         <= '0;
        end else begin
            gamma_phase    <= phase_next;
            pending_valid  <= pending_valid_next;
            pending_values <= pending_values_next;
            pending_null   <= pending_null_next;
            active_valid   <= active_valid_next;
            active_values  <= active_values_next;
            active_null    <= active_null_next;
            pulses         <= pulses_next;
        end
    end

endmodule

// File: tb/tb_bin_to_temporal_enc.sv
// Scoreboard bench for bin_to_temporal_enc: accepted frames are queued with the
// gamma cycle they should play in and compared against the outputs every cycle.
module tb_bin_to_temporal_enc;

    localparam int G  = 16;
    localparam int PW = 8;
    localparam int NC = 4;
    localparam int W  = 4;

    logic          aclk = 1'b0;
    logic          grst;
    logic          in_valid;
    logic          in_ready;
    logic [NC*W-1:0] in_values;
    logic [NC-1:0] in_null;
    logic [W-1:0]  gamma_phase;
    logic          gamma_start;
    logic [NC-1:0] pulses;
    logic          busy;

    bin_to_temporal_enc #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .NUM_CHANNELS(NC)) dut (
        .aclk(aclk), .grst(grst), .in_valid(in_valid), .in_ready(in_ready),
        .in_values(in_values), .in_null(in_null), .gamma_phase(gamma_phase),
        .gamma_start(gamma_start), .pulses(pulses), .busy(busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [NC*W-1:0] vals;
        logic [NC-1:0]   nul;
        int              play;
    } frame_t;

    frame_t sb[$];
    int     m_phase;
    int     cycle_cnt;
    bit     pend_busy;
    bit     last_hs;
    int     last_hs_phase;
    int     vectors;
    int     miscompares;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NC-1:0] expPulses(input frame_t f, input int p);
        logic [NC-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < NC; i++) begin
            v = int'(f.vals[i*W +: W]);
            r[i] = !f.nul[i] && (v <= p) && (p <= v + PW - 1);
        end
        return r;
    endfunction

    // Compare every output against the model's view of the current cycle.
    task automatic checkState();
        logic [NC-1:0] ep;
        logic          eb;
        while (sb.size() > 0 && sb[0].play < cycle_cnt) void'(sb.pop_front());
        ep = '0;
        eb = 1'b0;
        if (!grst && sb.size() > 0 && sb[0].play == cycle_cnt) begin
            ep = expPulses(sb[0], m_phase);
            eb = 1'b1;
        end
        checkOutput("phase", 32'(gamma_phase), 32'(m_phase));
        checkOutput("start", 32'(gamma_start), 32'(m_phase == 0));
        checkOutput("ready", 32'(in_ready), 32'(!pend_busy));
        checkOutput("busy", 32'(busy), 32'(eb));
        checkOutput("pulses", 32'(pulses), 32'(ep));
    endtask

    task automatic tick();
        frame_t f;
        last_hs = in_valid && !pend_busy && !grst;
        if (last_hs) begin
            f.vals = in_values;
            f.nul  = in_null;
            f.play = cycle_cnt + 1;
            sb.push_back(f);
            last_hs_phase = m_phase;
            if (m_phase != G - 1) pend_busy = 1'b1;
        end
        @(posedge aclk);
        if (!grst) begin
            if (m_phase == G - 1) begin
                pend_busy = 1'b0;
                cycle_cnt++;
            end
            m_phase = (m_phase + 1) % G;
        end
        @(negedge aclk);
        checkState();
    endtask

    task automatic applyStimulus(input logic [NC*W-1:0] vals, input logic [NC-1:0] nul);
        int guard;
        in_valid  = 1'b1;
        in_values = vals;
        in_null   = nul;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!last_hs && guard < 40);
        if (!last_hs) checkOutput("accept_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic waitPhase(input int p);
        while (m_phase != p) tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset asserted between edges, checked before any edge arrives.
    task automatic doReset();
        #2 grst = 1'b1;
        #1;
        sb.delete();
        m_phase   = 0;
        pend_busy = 1'b0;
        cycle_cnt += 2;
        checkState();
        @(negedge aclk);
        checkState();
        grst = 1'b0;
    endtask

    // Hand-derived pattern for values {3,0,15,7}, bit i = channel i.
    logic [NC-1:0] tbl [G] = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b1011,
                               4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0100};

    task automatic playCycleCheck(input logic [NC-1:0] mask, input int target);
        while (!(m_phase == 0 && cycle_cnt == target)) tick();
        for (int p = 0; p < G; p++) begin
            checkOutput("table_pulses", 32'(pulses), 32'(tbl[p] & mask));
            checkOutput("table_busy", 32'(busy), 32'(1));
            tick();
        end
    endtask

    logic [NC*W-1:0] frame_a;
    int              acc_cycle;

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_phase     = 0;
        cycle_cnt   = 0;
        pend_busy   = 1'b0;
        last_hs     = 1'b0;
        grst        = 1'b1;
        in_valid    = 1'b0;
        in_values   = '0;
        in_null     = '0;
        frame_a     = {4'd7, 4'd15, 4'd0, 4'd3};

        @(negedge aclk);
        checkState();
        grst = 1'b0;
        tick();
        checkOutput("first_phase", 32'(gamma_phase), 32'(1));

        // Basic frame, then the same frame with channel 1 nulled.
        waitPhase(5);
        acc_cycle = cycle_cnt;
        applyStimulus(frame_a, 4'b0000);
        playCycleCheck(4'b1111, acc_cycle + 1);
        idle(G + 2);
        waitPhase(5);
        acc_cycle = cycle_cnt;
        applyStimulus(frame_a, 4'b0010);
        playCycleCheck(4'b1101, acc_cycle + 1);
        idle(G);

        // Backpressure: B is held valid behind A and must land at phase 0.
        waitPhase(2);
        applyStimulus({4'd1, 4'd2, 4'd9, 4'd12}, 4'b0000);
        applyStimulus({4'd14, 4'd4, 4'd0, 4'd8}, 4'b1000);
        checkOutput("b_phase", 32'(last_hs_phase), 32'(0));
        idle(2 * G + 4);

        // Direct load into active at the last phase.
        waitPhase(G - 1);
        acc_cycle = cycle_cnt;
        applyStimulus(frame_a, 4'b0000);
        checkOutput("direct_busy", 32'(busy), 32'(1));
        playCycleCheck(4'b1111, acc_cycle + 1);
        idle(4);

        // Random frames at random offsets.
        for (int k = 0; k < 6; k++) begin
            idle($urandom_range(0, 20));
            applyStimulus(NC*W'($urandom), NC'($urandom_range(0, 15)));
        end
        idle(2 * G + 2);

        // Reset while channel 0 is mid-pulse.
        waitPhase(3);
        acc_cycle = cycle_cnt;
        applyStimulus({4'd0, 4'd0, 4'd0, 4'd5}, 4'b1110);
        while (!(cycle_cnt == acc_cycle + 1 && m_phase == 9)) tick();
        checkOutput("ch0_before_rst", 32'(pulses[0]), 32'(1));
        doReset();
        idle(2 * G);

        // Reset with a frame waiting in pending.
        waitPhase(4);
        applyStimulus({4'd2, 4'd3, 4'd4, 4'd5}, 4'b0000);
        idle(3);
        doReset();
        idle(2 * G);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
